morse_encoder: RTL

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_pkg.sv | 43 ++++
 rtl/morse_rom.sv | 57 +++++
 rtl/morse_encoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse encoder.
//   state_t      FSM state encoding
//   SPACE        code of the word-space symbol
//   MAX_VALID    highest code that maps to a symbol
//   DOT..WORD    durations in Morse time units
//   rom_t        lookup result {valid, len[2:0], pat[4:0]}
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  localparam int PAT_W = 5;

  localparam logic [5:0] SPACE     = 6'd36;
  localparam logic [5:0] MAX_VALID = 6'd36;

  localparam logic [2:0] DOT  = 3'd1;
  localparam logic [2:0] DASH = 3'd3;
  localparam logic [2:0] ELEM = 3'd1;
  localparam logic [2:0] CHAR = 3'd3;
  localparam logic [2:0] WORD = 3'd4;

  // pat is left-aligned: element i lives in bit PAT_W-1-i, 1 = dash.
  typedef struct packed {
    logic             valid;
    logic [2:0]       len;
    logic [PAT_W-1:0] pat;
  } rom_t;

  function automatic rom_t rom_entry(input logic [2:0] len, input logic [PAT_W-1:0] pat);
    rom_t r;
    r.valid = 1'b1;
    r.len   = len;
    r.pat   = pat;
    return r;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational code -> element pattern lookup.
//   code   in   6-bit symbol code (0-25 A-Z, 26-35 digits, 36 word space)
//   entry  out  {valid, len, pat}; word space is valid with len 0,
//               codes above MAX_VALID return all zeros (invalid)
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output rom_t       entry
);

  always_comb begin
    entry = '0;
    if (code <= MAX_VALID) begin
      case (code)
        6'd0:  entry = rom_entry(3'd2, 5'b01000); // A .-
        6'd1:  entry = rom_entry(3'd4, 5'b10000); // B -...
        6'd2:  entry = rom_entry(3'd4, 5'b10100); // C -.-.
        6'd3:  entry = rom_entry(3'd3, 5'b10000); // D -..
        6'd4:  entry = rom_entry(3'd1, 5'b00000); // E .
        6'd5:  entry = rom_entry(3'd4, 5'b00100); // F ..-.
        6'd6:  entry = rom_entry(3'd3, 5'b11000); // G --.
        6'd7:  entry = rom_entry(3'd4, 5'b00000); // H ....
        6'd8:  entry = rom_entry(3'd2, 5'b00000); // I ..
        6'd9:  entry = rom_entry(3'd4, 5'b01110); // J .---
        6'd10: entry = rom_entry(3'd3, 5'b10100); // K -.-
        6'd11: entry = rom_entry(3'd4, 5'b01000); // L .-..
        6'd12: entry = rom_entry(3'd2, 5'b11000); // M --
        6'd13: entry = rom_entry(3'd2, 5'b10000); // N -.
        6'd14: entry = rom_entry(3'd3, 5'b11100); // O ---
        6'd15: entry = rom_entry(3'd4, 5'b01100); // P .--.
        6'd16: entry = rom_entry(3'd4, 5'b11010); // Q --.-
        6'd17: entry = rom_entry(3'd3, 5'b01000); // R .-.
        6'd18: entry = rom_entry(3'd3, 5'b00000); // S ...
        6'd19: entry = rom_entry(3'd1, 5'b10000); // T -
        6'd20: entry = rom_entry(3'd3, 5'b00100); // U ..-
        6'd21: entry = rom_entry(3'd4, 5'b00010); // V ...-
        6'd22: entry = rom_entry(3'd3, 5'b01100); // W .--
        6'd23: entry = rom_entry(3'd4, 5'b10010); // X -..-
        6'd24: entry = rom_entry(3'd4, 5'b10110); // Y -.--
        6'd25: entry = rom_entry(3'd4, 5'b11000); // Z --..
        6'd26: entry = rom_entry(3'd5, 5'b11111); // 0 -----
        6'd27: entry = rom_entry(3'd5, 5'b01111); // 1 .----
        6'd28: entry = rom_entry(3'd5, 5'b00111); // 2 ..---
        6'd29: entry = rom_entry(3'd5, 5'b00011); // 3 ...--
        6'd30: entry = rom_entry(3'd5, 5'b00001); // 4 ....-
        6'd31: entry = rom_entry(3'd5, 5'b00000); // 5 .....
        6'd32: entry = rom_entry(3'd5, 5'b10000); // 6 -....
        6'd33: entry = rom_entry(3'd5, 5'b11000); // 7 --...
        6'd34: entry = rom_entry(3'd5, 5'b11100); // 8 ---..
        6'd35: entry = rom_entry(3'd5, 5'b11110); // 9 ----.
        default: entry = rom_entry(3'd0, 5'b00000); // word space
      endcase
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: serialises one symbol code at a time into a Morse key signal.
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   enable      encoder may run; low forces IDLE and discards the symbol
//   char_valid  char_code valid this cycle
//   char_code   6-bit symbol code
//   char_ready  encoder can accept a symbol (IDLE, enabled, out of reset)
//   morse_out   registered key output, 1 only in MARK
//   busy        symbol in progress
//   done        one-cycle pulse on the last cycle of a symbol's trailing gap
//   err         one-cycle pulse after an invalid code is accepted
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int             CW       = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0]  CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0]  CYC_PRE  = CW'(UNIT_CYCLES - 2);

  state_t           state;
  logic [CW-1:0]    cyc;     // cycle within the current unit
  logic [2:0]       unit;    // units elapsed in the current state
  logic [2:0]       idx;     // element index within the symbol
  logic [2:0]       len_q;
  logic [PAT_W-1:0] pat_q;
  logic             armed;   // low until the first edge after reset
  logic [2:0]       target;
  logic             unit_last, last_cyc, pre_last, take;
  rom_t             rom;

  morse_rom u_rom (
    .code  (char_code),
    .entry (rom)
  );

  assign char_ready = armed & enable & (state == IDLE);
  assign take       = char_ready & char_valid;

  // Length of the current state in units.
  always_comb begin
    target = DOT;
    case (state)
      MARK:     target = pat_q[3'd4 - idx] ? DASH : DOT;
      ELEM_GAP: target = ELEM;
      CHAR_GAP: target = CHAR;
      WORD_GAP: target = WORD;
      default:  target = DOT;
    endcase
  end

  assign unit_last = (unit == target - 3'd1);
  assign last_cyc  = unit_last & (cyc == CYC_LAST);
  // done is registered, so it is raised one cycle ahead of the gap's end.
  assign pre_last  = unit_last & (cyc == CYC_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cyc       <= '0;
      unit      <= '0;
      idx       <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      armed     <= 1'b0;
      morse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cyc       <= '0;
        unit      <= '0;
        idx       <= '0;
        morse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cyc  <= '0;
            unit <= '0;
            idx  <= '0;
            if (take) begin
              // Symbol is captured here; char_code is ignored afterwards.
              len_q <= rom.len;
              pat_q <= rom.pat;
              if (!rom.valid) begin
                err  <= 1'b1;
                done <= 1'b1;
              end else if (char_code == SPACE) begin
                state <= WORD_GAP;
                busy  <= 1'b1;
              end else begin
                state     <= MARK;
                morse_out <= 1'b1;
                busy      <= 1'b1;
              end
            end
          end
          default: begin
            if (last_cyc) begin
              cyc  <= '0;
              unit <= '0;
              case (state)
                MARK: begin
                  morse_out <= 1'b0;
                  state     <= (idx == len_q - 3'd1) ? CHAR_GAP : ELEM_GAP;
                end
                ELEM_GAP: begin
                  morse_out <= 1'b1;
                  idx       <= idx + 3'd1;
                  state     <= MARK;
                end
                default: begin
                  busy  <= 1'b0;
                  idx   <= '0;
                  state <= IDLE;
                end
              endcase
            end else begin
              if (cyc == CYC_LAST) begin
                cyc  <= '0;
                unit <= unit + 3'd1;
              end else begin
                cyc <= cyc + CW'(1);
              end
              if ((state == CHAR_GAP || state == WORD_GAP) && pre_last)
                done <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
